// File: rtl/bday_pkg.sv
// Shared types for the birthday-message display path: segment patterns and
// the scan-multiplexer state encoding.
package bday_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    SC_IDLE  = 2'd0,
    SC_BLANK = 2'd1,
    SC_DRIVE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg_scan_mux.sv
// Time-multiplexes NUM_DIGITS active-low 7-segment patterns onto one shared
// segment bus with per-digit anode enables, anode dead-time and 4-bit PWM.
module seg_scan_mux
  import bday_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned SEG_W            = 7,
  parameter int unsigned REFRESH_DIV      = 50_000,
  parameter int unsigned BLANK_CYCLES     = 500,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  en,
  input  logic [3:0]            bright,
  input  logic [SEG_W-1:0]      digits_in [NUM_DIGITS],
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic                  frame_done,
  output scan_state_t           state_dbg
);

  localparam int unsigned SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]     BLANK_LAST = SLOT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [DIG_W-1:0]      DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam scan_state_t           SLOT_START = (BLANK_CYCLES == 0) ? SC_DRIVE : SC_BLANK;

  if (REFRESH_DIV < 2 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_chk
    $error("seg_scan_mux: need REFRESH_DIV >= 2 and BLANK_CYCLES < REFRESH_DIV");
  end

  scan_state_t           state_q, state_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [3:0]            pwm_q, pwm_d;
  logic [SEG_W-1:0]      buf_q [NUM_DIGITS];
  logic [SEG_W-1:0]      buf_d [NUM_DIGITS];
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  gate_on;
  logic [NUM_DIGITS-1:0] an_onehot;

  assign gate_on   = (bright == 4'hF) || (pwm_q < bright);
  assign an_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_q;

  // Outputs are computed from the current state and registered, so the pins
  // trail the scan state by exactly one cycle.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    slot_d       = slot_q;
    pwm_d        = pwm_q;
    buf_d        = buf_q;
    seg_d        = '1;
    an_d         = AN_OFF;
    frame_done_d = 1'b0;

    if (state_q == SC_IDLE) begin
      if (en) begin
        digit_d = '0;
        slot_d  = '0;
        pwm_d   = '0;
        buf_d   = digits_in;
        state_d = SLOT_START;
      end
    end else if (!en) begin
      state_d = SC_IDLE;
      digit_d = '0;
      slot_d  = '0;
      pwm_d   = '0;
    end else begin
      if (state_q == SC_DRIVE) begin
        seg_d = buf_q[digit_q];
        if (gate_on) begin
          an_d = ANODE_ACTIVE_LOW ? ~an_onehot : an_onehot;
        end
        pwm_d = pwm_q + 4'd1;
      end

      if (slot_q == SLOT_LAST) begin
        slot_d  = '0;
        pwm_d   = '0;
        state_d = SLOT_START;
        if (digit_q == DIG_LAST) begin
          digit_d      = '0;
          frame_done_d = 1'b1;
          buf_d        = digits_in;
        end else begin
          digit_d = digit_q + DIG_W'(1);
        end
      end else begin
        slot_d = slot_q + SLOT_W'(1);
        if (state_q == SC_BLANK && slot_q == BLANK_LAST) begin
          state_d = SC_DRIVE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= SC_IDLE;
      digit_q      <= '0;
      slot_q       <= '0;
      pwm_q        <= '0;
      seg_q        <= '1;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        buf_q[i] <= '1;
      end
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      slot_q       <= slot_d;
      pwm_q        <= pwm_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
      buf_q        <= buf_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Downstream of the scrolling-message generator. It takes the four parallel active-low 7-segment digit patterns and time-multiplexes them onto one shared segment bus plus per-digit anode enables. This matches a board with common segment lines.
- Snapshots the digit patterns once per scan frame, so a frame never tears mid-scroll.
- Inserts anode dead-time between digits to avoid ghosting.
- Applies 4-bit PWM brightness within each digit slot.

Parameters:
NUM_DIGITS, 4, number of digits scanned; digit 0 scanned first.
SEG_W, 7, segment bits per digit; active-low, '1 = segment off.
REFRESH_DIV, 50_000, clk cycles per digit slot; must be >= 2.
BLANK_CYCLES, 500, dead-time cycles at the start of each slot; 0 <= BLANK_CYCLES < REFRESH_DIV, enforced by an elaboration check.
ANODE_ACTIVE_LOW, 1, polarity of the an_out enables.

Ports:
clk  input  1  system clock; the only clock.
rst_b  input  1  asynchronous, active-low reset.
en  input  1  scan enable; synchronous.
bright  input  4  brightness: 0 = dark, 15 = full on.
digits_in  input  NUM_DIGITS x SEG_W  unpacked array of digit patterns from the message generator.
seg_out  output  SEG_W  shared segment bus, active-low.
an_out  output  NUM_DIGITS  digit enables, one-hot at the active level or all inactive.
frame_done  output  1  one-cycle pulse at the end of the last digit's slot.

Behaviour:
- Single clock clk; reset rst_b is asynchronous, active-low. All outputs are registered.
- Reset values:
  - state IDLE
  - seg_out all '1
  - an_out all inactive (4'hF when ANODE_ACTIVE_LOW)
  - frame_done 0
  - frame buffer all '1
  - digit index, slot counter and PWM counter all 0
- States: IDLE, BLANK, DRIVE (scan_state_t).
- IDLE:
  - Outputs are blank/inactive.
  - When en=1 at a clock edge: digit <= 0, slot_cnt <= 0, buffer <= digits_in (snapshot), then go to BLANK. If BLANK_CYCLES==0, go straight to DRIVE.
- slot_cnt increments every non-IDLE cycle over the range 0..REFRESH_DIV-1.
- BLANK (slot_cnt < BLANK_CYCLES):
  - an_out inactive, seg_out all '1.
  - Go to DRIVE when slot_cnt == BLANK_CYCLES-1.
- DRIVE (slot_cnt from BLANK_CYCLES to REFRESH_DIV-1):
  - seg_out = buffer[digit].
  - The anode for `digit` is active only when the PWM gate is on: gate on iff pwm_cnt < bright, or bright == 4'hF. With bright == 0 the anode is never active.
  - pwm_cnt is 4 bits: it clears at each slot start, increments each DRIVE cycle and wraps 15 -> 0.
- End of slot (slot_cnt == REFRESH_DIV-1):
  - slot_cnt <= 0, pwm_cnt <= 0, next state BLANK (or DRIVE if BLANK_CYCLES==0).
  - If digit < NUM_DIGITS-1: digit <= digit+1.
  - Otherwise: digit <= 0, frame_done pulses for the next cycle, and buffer <= digits_in (new frame snapshot).
- Latency:
  - First active anode appears BLANK_CYCLES+1 cycles after the edge that samples en=1, since outputs are registered one cycle behind the state.
  - Frame period = NUM_DIGITS*REFRESH_DIV cycles.
- en=0 in any non-IDLE state: next edge goes to IDLE and outputs go blank/inactive. This is allowed mid-slot. Counters clear. frame_done is not pulsed.
- Re-enable always restarts at digit 0 with a fresh snapshot.
- digits_in changes mid-frame have no visible effect until the next frame boundary. digits_in is a slow, quasi-static producer output and needs no synchroniser.
- Asynchronous reset mid-operation forces the reset values immediately, without waiting for a clock edge.
- A bright change takes effect on the next cycle's gate decision; no glitch on seg_out.

Decomposition:
- bday_pkg gains:
  - typedef seg_t (logic [6:0])
  - constant SEG_BLANK = 7'h7F
  - enum scan_state_t {SC_IDLE, SC_BLANK, SC_DRIVE}
- Counter widths are derived with $clog2 inside the module.
- No sub-module: the PWM gate is a single compare and stays inline.
- The message generator's led array connects directly to digits_in.

Test Plan:
Use REFRESH_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=4, ANODE_ACTIVE_LOW=1 for all scenarios.
1. Assert rst_b=0 with random inputs -> seg_out=7'h7F, an_out=4'hF, frame_done=0 immediately, with no clock needed.
2. en=1, bright=15, digits_in={H,A,P,P} -> an_out=4'hF for 2 cycles, then 1110 with seg_out=H for 6 cycles; then 2 blank cycles, then 1101 with A, and so on. frame_done pulses every 32 cycles.
3. Change digits_in to {Y,BLANK,B,D} during digit 1's DRIVE -> digits 1..3 still show A,P,P. The new values appear starting at the next digit 0 slot, immediately after the frame_done pulse.
4. bright=4 -> each 6-cycle DRIVE window shows the anode active for exactly 4 cycles, then inactive for 2. bright=0 -> an_out stays 4'hF throughout.
5. Drop en during digit 2's DRIVE -> next cycle an_out=4'hF, seg_out=7'h7F, no frame_done. Re-raise en -> scan restarts with 2 blank cycles, then digit 0.
6. Pulse rst_b low mid-DRIVE, then release with en=1 -> outputs go blank asynchronously; after release the scan restarts at digit 0 exactly as in scenario 2.
